dispatch_unit: RTL and testbench
================================

Name: dispatch_unit

Overview:
- In-order issue stage that sits between the decoder's instruction handshake and the reservation station's dispatch write port.
- Accepts one decoded instruction per cycle and allocates its ROB tag.
- Renames source registers through an internal register-status table, reads the register file, and forwards same-cycle CDB results (ALU and LSB).
- Drives a registered, one-cycle dispatch packet: dispatch signal, inst, imm, pc, dest, Vj/Vk/Qj/Qk.

Parameters:
ROB_TAG_W, 4, ROB tag width; tag 0 is NULL_TAG, valid tags are 1..2^ROB_TAG_W-1
INST_W, 6, inner-instruction opcode width
REG_NUM, 32, architectural registers; x0 is never renamed

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid_in  in  1  decoded instruction available
dec_ready_out  out  1  dispatch accepts this cycle (combinational)
dec_inst_in  in  INST_W  inner opcode
dec_rs1_in / dec_rs2_in / dec_rd_in  in  5 each  register indices
dec_use_rs2_in  in  1  instruction reads rs2 (otherwise Vk=imm path, Qk=NULL)
dec_imm_in / dec_pc_in  in  32 each  immediate, pc
rf_rs1_out / rf_rs2_out  out  5 each  register-file read addresses (= dec_rs1_in/rs2_in)
rf_val1_in / rf_val2_in  in  32 each  register-file read data (same cycle)
rob_tail_tag_in  in  ROB_TAG_W  tag the ROB will assign next (never NULL)
rob_full_in  in  1  ROB cannot accept
rob_alloc_out  out  1  allocate ROB entry (= handshake fire)
rs_full_in  in  1  reservation station has no free entry
commit_signal_in  in  1  ROB commits
commit_rd_in  in  5  committed rd
commit_tag_in  in  ROB_TAG_W  committed tag
flush_in  in  1  mispredict flush
alu_broadcast_signal_in, alu_result_in[32], alu_dest_tag_in[ROB_TAG_W]  in  ALU CDB
lsb_broadcast_signal_in, lsb_result_in[32], lsb_dest_tag_in[ROB_TAG_W]  in  LSB CDB
dis_new_inst_signal_out  out  1  one-cycle pulse, packet valid
dis_inst_out  out  INST_W; dis_imm_out, dis_pc_out  out  32; dis_dest_out  out  ROB_TAG_W
dis_Vj_out, dis_Vk_out  out  32; dis_Qj_out, dis_Qk_out  out  ROB_TAG_W

Behaviour:
- State machine: RUN, FLUSH.
  - Reset enters FLUSH.
  - FLUSH lasts exactly one cycle, then RUN.
  - flush_in in any state: next state FLUSH.
- Reset (sync):
  - All outputs registered 0; dis_Qj/Qk_out = NULL_TAG.
  - Register-status table all NULL_TAG.
- Handshake:
  - dec_ready_out = RUN & ~flush_in & ~rob_full_in & ~rs_full_in.
  - fire = dec_valid_in & dec_ready_out.
  - rob_alloc_out = fire.
- Output packet and latency:
  - On fire, packet registered at the next edge and dis_new_inst_signal_out=1 for exactly that cycle; otherwise 0.
  - Packet fields hold their last values while the signal is 0.
- Operand resolution for each source s (rs1→j, rs2→k), in priority order:
  - s==x0: V=0, Q=NULL.
  - status[s]==NULL: V=rf value, Q=NULL.
  - status[s] matches ALU broadcast this cycle: V=alu_result, Q=NULL.
  - status[s] matches LSB broadcast this cycle: V=lsb_result, Q=NULL.
  - Otherwise: V=0, Q=status[s].
  - If ~dec_use_rs2_in: Vk=0, Qk=NULL.
- Register status:
  - On fire with rd!=0: status[rd] <= rob_tail_tag_in.
  - On commit: status[commit_rd] <= NULL only if status[commit_rd]==commit_tag.
  - Same cycle, same register, fire and commit: fire wins.
  - Source lookup uses the pre-update table, so rd==rs1 reads the old mapping.
- Flush:
  - Clears the whole table.
  - Suppresses dispatch that cycle; dis_new_inst_signal_out=0 next cycle.
  - Takes priority over commit and fire.
- dis_dest_out = rob_tail_tag_in captured at fire.

Optional Feature:
DISPATCH_BYPASS_EN
- Defined: CDB forwarding as above.
- Undefined:
  - No forwarding.
  - dec_ready_out additionally requires that neither active broadcast tag equals a pending source tag of the current instruction. This prevents a lost wakeup; the instruction issues the following cycle reading the committed/pending state.

Decomposition:
- Shared header: NULL_TAG, ZERO_WORD, ROB_TAG_RANGE, INNER_INST_RANGE, REG_INDEX_RANGE, ZERO_REG_INDEX, TRUE/FALSE.
- Sub-module register_status_table: 32 tag entries, two combinational read ports, one rename write, one conditional commit clear, flush clear.

Test Plan:
- Reset, then decode add x3,x1,x2 (rf x1=5, x2=7, tail=1) → next cycle: signal=1, Vj=5, Vk=7, Qj=Qk=0, dest=1; the following cycle signal=0.
- Dispatch rd=x3 with tag 1, then sub x4,x3,x1 with tag 2 → Qj=1, Vj=0; commit (x3, tag 1), then a read of x3 → Qj=0, Vj=rf.
- Pending x3=tag 2 and ALU broadcast tag 2 value 0x99 in the same cycle as the consumer's dispatch → bypass: Qj=0, Vj=0x99; no bypass: one-cycle stall, then issue.
- rs_full_in=1 or rob_full_in=1 with dec_valid_in=1 → dec_ready_out=0, no pulse; deassert → issue next cycle.
- Rename x5 to tag 3, flush_in pulse while dec_valid_in=1 → no dispatch for 2 cycles (flush cycle plus FLUSH state); subsequent x5 read → Qj=0.
- Stale commit: x6 renamed tag 4 then tag 5; commit (x6, tag 4) → status[x6] stays 5; fire and commit on the same rd in the same cycle → new tag kept.

Source files
------------

// File: rtl/dispatch_unit_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_unit_pkg
//   Shared types, constants and helpers for the dispatch stage.
//   - NULL_TAG / ZERO_WORD / ZERO_REG_INDEX / TRUE / FALSE constants
//   - rob_tag_t, inst_t, reg_idx_t, word_t field types (the tag, opcode and
//     register-index ranges of the bus)
//   - dispatch_state_e FSM encoding (StRun, StFlush)
//   - operand_t plus resolve_operand(), the rename/forward priority chain
// -----------------------------------------------------------------------------
package dispatch_unit_pkg;

    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned INST_W    = 6;
    localparam int unsigned REG_NUM   = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned WORD_W    = 32;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef logic [INST_W-1:0]    inst_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]    word_t;

    localparam rob_tag_t NULL_TAG       = '0;
    localparam word_t    ZERO_WORD      = '0;
    localparam reg_idx_t ZERO_REG_INDEX = '0;
    localparam logic     TRUE           = 1'b1;
    localparam logic     FALSE          = 1'b0;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StFlush = 1'b1
    } dispatch_state_e;

    typedef struct packed {
        word_t    v;
        rob_tag_t q;
    } operand_t;

    // Resolve one source operand. Priority: x0, not renamed, ALU CDB, LSB CDB,
    // still pending. The *_fwd enables gate the CDB paths off when forwarding
    // is not built in.
    function automatic operand_t resolve_operand(
        input reg_idx_t src,
        input rob_tag_t tag,
        input word_t    rf_val,
        input logic     alu_fwd,
        input rob_tag_t alu_tag,
        input word_t    alu_val,
        input logic     lsb_fwd,
        input rob_tag_t lsb_tag,
        input word_t    lsb_val
    );
        operand_t op;
        op.v = ZERO_WORD;
        op.q = NULL_TAG;
        if (src == ZERO_REG_INDEX) begin
            op.v = ZERO_WORD;
        end else if (tag == NULL_TAG) begin
            op.v = rf_val;
        end else if ((alu_fwd == TRUE) && (tag == alu_tag)) begin
            op.v = alu_val;
        end else if ((lsb_fwd == TRUE) && (tag == lsb_tag)) begin
            op.v = lsb_val;
        end else begin
            op.q = tag;
        end
        return op;
    endfunction

    // A live broadcast that carries the tag a pending source is waiting for.
    function automatic logic tag_hit(
        input logic     pending,
        input rob_tag_t tag,
        input logic     bc_valid,
        input rob_tag_t bc_tag
    );
        return pending && bc_valid && (tag == bc_tag);
    endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// -----------------------------------------------------------------------------
// dispatch_unit_if
//   Bundles every non-clock/reset signal around the dispatch stage.
//   slave  : view of the dispatch unit (decoder/RF/ROB/RS/CDB in, packet out)
//   master : view of the surrounding pipeline (drives inputs, sees packet)
//   Groups: decoder handshake (dec_*), register-file read (rf_*), ROB
//   allocation/commit (rob_*, commit_*), RS back-pressure (rs_full_in),
//   flush, ALU/LSB CDBs, and the registered dispatch packet (dis_*).
// -----------------------------------------------------------------------------
interface dispatch_unit_if;
    import dispatch_unit_pkg::*;

    // Decoder handshake
    logic     dec_valid_in;
    logic     dec_ready_out;
    inst_t    dec_inst_in;
    reg_idx_t dec_rs1_in;
    reg_idx_t dec_rs2_in;
    reg_idx_t dec_rd_in;
    logic     dec_use_rs2_in;
    word_t    dec_imm_in;
    word_t    dec_pc_in;

    // Register file read
    reg_idx_t rf_rs1_out;
    reg_idx_t rf_rs2_out;
    word_t    rf_val1_in;
    word_t    rf_val2_in;

    // ROB / RS
    rob_tag_t rob_tail_tag_in;
    logic     rob_full_in;
    logic     rob_alloc_out;
    logic     rs_full_in;
    logic     commit_signal_in;
    reg_idx_t commit_rd_in;
    rob_tag_t commit_tag_in;
    logic     flush_in;

    // Common data buses
    logic     alu_broadcast_signal_in;
    word_t    alu_result_in;
    rob_tag_t alu_dest_tag_in;
    logic     lsb_broadcast_signal_in;
    word_t    lsb_result_in;
    rob_tag_t lsb_dest_tag_in;

    // Dispatch packet
    logic     dis_new_inst_signal_out;
    inst_t    dis_inst_out;
    word_t    dis_imm_out;
    word_t    dis_pc_out;
    rob_tag_t dis_dest_out;
    word_t    dis_Vj_out;
    word_t    dis_Vk_out;
    rob_tag_t dis_Qj_out;
    rob_tag_t dis_Qk_out;

    modport slave (
        input  dec_valid_in, dec_inst_in, dec_rs1_in, dec_rs2_in, dec_rd_in,
        input  dec_use_rs2_in, dec_imm_in, dec_pc_in,
        output dec_ready_out,
        output rf_rs1_out, rf_rs2_out,
        input  rf_val1_in, rf_val2_in,
        input  rob_tail_tag_in, rob_full_in, rs_full_in,
        output rob_alloc_out,
        input  commit_signal_in, commit_rd_in, commit_tag_in, flush_in,
        input  alu_broadcast_signal_in, alu_result_in, alu_dest_tag_in,
        input  lsb_broadcast_signal_in, lsb_result_in, lsb_dest_tag_in,
        output dis_new_inst_signal_out, dis_inst_out, dis_imm_out, dis_pc_out,
        output dis_dest_out, dis_Vj_out, dis_Vk_out, dis_Qj_out, dis_Qk_out
    );

    modport master (
        output dec_valid_in, dec_inst_in, dec_rs1_in, dec_rs2_in, dec_rd_in,
        output dec_use_rs2_in, dec_imm_in, dec_pc_in,
        input  dec_ready_out,
        input  rf_rs1_out, rf_rs2_out,
        output rf_val1_in, rf_val2_in,
        output rob_tail_tag_in, rob_full_in, rs_full_in,
        input  rob_alloc_out,
        output commit_signal_in, commit_rd_in, commit_tag_in, flush_in,
        output alu_broadcast_signal_in, alu_result_in, alu_dest_tag_in,
        output lsb_broadcast_signal_in, lsb_result_in, lsb_dest_tag_in,
        input  dis_new_inst_signal_out, dis_inst_out, dis_imm_out, dis_pc_out,
        input  dis_dest_out, dis_Vj_out, dis_Vk_out, dis_Qj_out, dis_Qk_out
    );

endinterface

// File: rtl/dispatch_unit_register_status_table.sv
// -----------------------------------------------------------------------------
// dispatch_unit_register_status_table
//   One ROB tag per architectural register (NULL_TAG = value is in the RF).
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     i_rd_addr1/2, o_rd_tag1/2    two combinational lookups (pre-update)
//     i_rename_en/_rd/_tag         allocate a new producer tag for rd
//     i_commit_en/_rd/_tag         clear rd only if it still maps to that tag
//     i_flush                      clear the whole table
//   Priority per entry: reset/flush > rename > commit clear. x0 never renamed.
// -----------------------------------------------------------------------------
module dispatch_unit_register_status_table
    import dispatch_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t i_rd_addr1,
    input  reg_idx_t i_rd_addr2,
    output rob_tag_t o_rd_tag1,
    output rob_tag_t o_rd_tag2,
    input  logic     i_rename_en,
    input  reg_idx_t i_rename_rd,
    input  rob_tag_t i_rename_tag,
    input  logic     i_commit_en,
    input  reg_idx_t i_commit_rd,
    input  rob_tag_t i_commit_tag,
    input  logic     i_flush
);

    rob_tag_t r_status [REG_NUM];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                r_status[i] <= NULL_TAG;
            end
        end else begin
            for (int i = 1; i < int'(REG_NUM); i++) begin
                if (i_rename_en && (i_rename_rd == reg_idx_t'(i))) begin
                    r_status[i] <= i_rename_tag;
                end else if (i_commit_en && (i_commit_rd == reg_idx_t'(i)) &&
                             (r_status[i] == i_commit_tag)) begin
                    // A newer rename leaves a stale commit without effect.
                    r_status[i] <= NULL_TAG;
                end
            end
            r_status[0] <= NULL_TAG;
        end
    end

    assign o_rd_tag1 = r_status[i_rd_addr1];
    assign o_rd_tag2 = r_status[i_rd_addr2];

endmodule

// File: rtl/dispatch_unit.sv
// -----------------------------------------------------------------------------
// dispatch_unit
//   In-order issue stage between the decoder and the reservation station.
//   Accepts one instruction per cycle, allocates its ROB tag, renames rs1/rs2
//   through the register-status table, reads the RF and emits a registered
//   one-cycle dispatch packet.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset (enters the one-cycle FLUSH state)
//     bus  dispatch_unit_if.slave: decoder handshake, RF read, ROB/RS status,
//          commit, flush, ALU/LSB CDBs and the dis_* packet
//   Build option DISPATCH_BYPASS_EN:
//     defined   - same-cycle ALU/LSB CDB results are forwarded into Vj/Vk
//     undefined - no forwarding; an instruction whose pending source tag is
//                 being broadcast this cycle is held one cycle so the wakeup
//                 is not lost between dispatch and RS insertion
// -----------------------------------------------------------------------------
module dispatch_unit
    import dispatch_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    dispatch_unit_if.slave bus
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    dispatch_state_e r_state;
    dispatch_state_e w_state_next;

    rob_tag_t w_tag1;
    rob_tag_t w_tag2;
    operand_t w_op_j;
    operand_t w_op_k_raw;
    operand_t w_op_k;
    logic     w_alu_fwd;
    logic     w_lsb_fwd;
    logic     w_hazard;
    logic     w_dec_ready;
    logic     w_fire;
    logic     w_rename_en;

    logic     r_dis_signal;
    inst_t    r_dis_inst;
    word_t    r_dis_imm;
    word_t    r_dis_pc;
    rob_tag_t r_dis_dest;
    word_t    r_dis_vj;
    word_t    r_dis_vk;
    rob_tag_t r_dis_qj;
    rob_tag_t r_dis_qk;

    // ------------------------------------------------------------------
    // Register-status table
    // ------------------------------------------------------------------
    assign w_rename_en = w_fire && (bus.dec_rd_in != ZERO_REG_INDEX);

    dispatch_unit_register_status_table u_rst_table (
        .clk          (clk),
        .rst          (rst),
        .i_rd_addr1   (bus.dec_rs1_in),
        .i_rd_addr2   (bus.dec_rs2_in),
        .o_rd_tag1    (w_tag1),
        .o_rd_tag2    (w_tag2),
        .i_rename_en  (w_rename_en),
        .i_rename_rd  (bus.dec_rd_in),
        .i_rename_tag (bus.rob_tail_tag_in),
        .i_commit_en  (bus.commit_signal_in),
        .i_commit_rd  (bus.commit_rd_in),
        .i_commit_tag (bus.commit_tag_in),
        .i_flush      (bus.flush_in)
    );

    // ------------------------------------------------------------------
    // Operand resolution
    // ------------------------------------------------------------------
`ifdef DISPATCH_BYPASS_EN
    assign w_alu_fwd = bus.alu_broadcast_signal_in;
    assign w_lsb_fwd = bus.lsb_broadcast_signal_in;
    assign w_hazard  = FALSE;
`else
    logic w_pend_j;
    logic w_pend_k;

    assign w_alu_fwd = FALSE;
    assign w_lsb_fwd = FALSE;
    assign w_pend_j  = (bus.dec_rs1_in != ZERO_REG_INDEX) && (w_tag1 != NULL_TAG);
    assign w_pend_k  = bus.dec_use_rs2_in && (bus.dec_rs2_in != ZERO_REG_INDEX) &&
                       (w_tag2 != NULL_TAG);
    // Without forwarding a broadcast of a pending tag would be missed by the
    // RS entry that only appears next cycle, so hold the instruction back.
    assign w_hazard  =
        tag_hit(w_pend_j, w_tag1, bus.alu_broadcast_signal_in, bus.alu_dest_tag_in) ||
        tag_hit(w_pend_j, w_tag1, bus.lsb_broadcast_signal_in, bus.lsb_dest_tag_in) ||
        tag_hit(w_pend_k, w_tag2, bus.alu_broadcast_signal_in, bus.alu_dest_tag_in) ||
        tag_hit(w_pend_k, w_tag2, bus.lsb_broadcast_signal_in, bus.lsb_dest_tag_in);
`endif

    assign w_op_j = resolve_operand(bus.dec_rs1_in, w_tag1, bus.rf_val1_in,
                                    w_alu_fwd, bus.alu_dest_tag_in, bus.alu_result_in,
                                    w_lsb_fwd, bus.lsb_dest_tag_in, bus.lsb_result_in);

    assign w_op_k_raw = resolve_operand(bus.dec_rs2_in, w_tag2, bus.rf_val2_in,
                                        w_alu_fwd, bus.alu_dest_tag_in, bus.alu_result_in,
                                        w_lsb_fwd, bus.lsb_dest_tag_in, bus.lsb_result_in);

    // Immediate-form instructions carry their second operand in imm.
    always_comb begin
        w_op_k = w_op_k_raw;
        if (!bus.dec_use_rs2_in) begin
            w_op_k.v = ZERO_WORD;
            w_op_k.q = NULL_TAG;
        end
    end

    // ------------------------------------------------------------------
    // FSM and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFlush;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dec_ready  = FALSE;
        case (r_state)
            StRun: begin
                w_state_next = StRun;
                w_dec_ready  = !bus.flush_in && !bus.rob_full_in && !bus.rs_full_in &&
                               !w_hazard;
            end
            StFlush: begin
                w_state_next = StRun;
            end
            default: begin
                w_state_next = StFlush;
            end
        endcase
        if (bus.flush_in) begin
            w_state_next = StFlush;
        end
    end

    assign w_fire = bus.dec_valid_in && w_dec_ready;

    assign bus.dec_ready_out = w_dec_ready;
    assign bus.rob_alloc_out = w_fire;
    assign bus.rf_rs1_out    = bus.dec_rs1_in;
    assign bus.rf_rs2_out    = bus.dec_rs2_in;

    // ------------------------------------------------------------------
    // Dispatch packet register; fields hold between pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dis_signal <= FALSE;
            r_dis_inst   <= '0;
            r_dis_imm    <= ZERO_WORD;
            r_dis_pc     <= ZERO_WORD;
            r_dis_dest   <= NULL_TAG;
            r_dis_vj     <= ZERO_WORD;
            r_dis_vk     <= ZERO_WORD;
            r_dis_qj     <= NULL_TAG;
            r_dis_qk     <= NULL_TAG;
        end else begin
            r_dis_signal <= w_fire;
            if (w_fire) begin
                r_dis_inst <= bus.dec_inst_in;
                r_dis_imm  <= bus.dec_imm_in;
                r_dis_pc   <= bus.dec_pc_in;
                r_dis_dest <= bus.rob_tail_tag_in;
                r_dis_vj   <= w_op_j.v;
                r_dis_vk   <= w_op_k.v;
                r_dis_qj   <= w_op_j.q;
                r_dis_qk   <= w_op_k.q;
            end
        end
    end

    assign bus.dis_new_inst_signal_out = r_dis_signal;
    assign bus.dis_inst_out            = r_dis_inst;
    assign bus.dis_imm_out             = r_dis_imm;
    assign bus.dis_pc_out              = r_dis_pc;
    assign bus.dis_dest_out            = r_dis_dest;
    assign bus.dis_Vj_out              = r_dis_vj;
    assign bus.dis_Vk_out              = r_dis_vk;
    assign bus.dis_Qj_out              = r_dis_qj;
    assign bus.dis_Qk_out              = r_dis_qk;

endmodule

// File: tb/tb_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_dispatch_unit
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a behavioural model (register map array + expected packet).
// -----------------------------------------------------------------------------
module tb_dispatch_unit;

    logic clk;
    logic rst;

    dispatch_unit_if bus ();

    dispatch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          m_status [32];
    bit          m_run;
    bit          e_sig;
    logic [31:0] e_inst, e_imm, e_pc, e_dest, e_vj, e_vk, e_qj, e_qk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.dec_valid_in            = 1'b0;
        bus.dec_inst_in             = '0;
        bus.dec_rs1_in              = '0;
        bus.dec_rs2_in              = '0;
        bus.dec_rd_in               = '0;
        bus.dec_use_rs2_in          = 1'b0;
        bus.dec_imm_in              = '0;
        bus.dec_pc_in               = '0;
        bus.rf_val1_in              = '0;
        bus.rf_val2_in              = '0;
        bus.rob_tail_tag_in         = 4'd1;
        bus.rob_full_in             = 1'b0;
        bus.rs_full_in              = 1'b0;
        bus.commit_signal_in        = 1'b0;
        bus.commit_rd_in            = '0;
        bus.commit_tag_in           = '0;
        bus.flush_in                = 1'b0;
        bus.alu_broadcast_signal_in = 1'b0;
        bus.alu_result_in           = '0;
        bus.alu_dest_tag_in         = '0;
        bus.lsb_broadcast_signal_in = 1'b0;
        bus.lsb_result_in           = '0;
        bus.lsb_dest_tag_in         = '0;
    endtask

    task automatic set_dec(input int inst, input int rs1, input int rs2, input int rd,
                           input bit use2, input logic [31:0] imm, input logic [31:0] pc,
                           input logic [31:0] v1, input logic [31:0] v2, input int tail);
        clear_inputs();
        bus.dec_valid_in    = 1'b1;
        bus.dec_inst_in     = 6'(inst);
        bus.dec_rs1_in      = 5'(rs1);
        bus.dec_rs2_in      = 5'(rs2);
        bus.dec_rd_in       = 5'(rd);
        bus.dec_use_rs2_in  = use2;
        bus.dec_imm_in      = imm;
        bus.dec_pc_in       = pc;
        bus.rf_val1_in      = v1;
        bus.rf_val2_in      = v2;
        bus.rob_tail_tag_in = 4'(tail);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_status[i] = 0;
        m_run  = 1'b0;
        e_sig  = 1'b0;
        e_inst = '0; e_imm = '0; e_pc = '0; e_dest = '0;
        e_vj   = '0; e_vk  = '0; e_qj = '0; e_qk   = '0;
    endtask

    // What a source register yields this cycle, from the register map and CDBs.
    task automatic model_src(input int r, input bit used, input logic [31:0] rf,
                             output logic [31:0] v, output int q, output bit stall);
        bit alu_hit;
        bit lsb_hit;
        v = '0;
        q = 0;
        stall = 1'b0;
        if (!used || r == 0) return;
        if (m_status[r] == 0) begin
            v = rf;
            return;
        end
        alu_hit = bus.alu_broadcast_signal_in && (int'(bus.alu_dest_tag_in) == m_status[r]);
        lsb_hit = bus.lsb_broadcast_signal_in && (int'(bus.lsb_dest_tag_in) == m_status[r]);
`ifdef DISPATCH_BYPASS_EN
        if (alu_hit) v = bus.alu_result_in;
        else if (lsb_hit) v = bus.lsb_result_in;
        else q = m_status[r];
`else
        q = m_status[r];
        stall = alu_hit || lsb_hit;
`endif
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic cycle();
        logic [31:0] vj, vk;
        int qj, qk, crd;
        bit sj, sk, ready, fire;
        #1;
        model_src(int'(bus.dec_rs1_in), 1'b1, bus.rf_val1_in, vj, qj, sj);
        model_src(int'(bus.dec_rs2_in), bus.dec_use_rs2_in, bus.rf_val2_in, vk, qk, sk);
        ready = m_run && !bus.flush_in && !bus.rob_full_in && !bus.rs_full_in && !sj && !sk;
        fire  = ready && bus.dec_valid_in;
        chk("dec_ready", 32'(bus.dec_ready_out), 32'(ready));
        chk("rob_alloc", 32'(bus.rob_alloc_out), 32'(fire));
        chk("rf_rs1", 32'(bus.rf_rs1_out), 32'(bus.dec_rs1_in));
        chk("rf_rs2", 32'(bus.rf_rs2_out), 32'(bus.dec_rs2_in));
        if (fire) begin
            e_inst = 32'(bus.dec_inst_in);
            e_imm  = bus.dec_imm_in;
            e_pc   = bus.dec_pc_in;
            e_dest = 32'(bus.rob_tail_tag_in);
            e_vj   = vj;
            e_vk   = vk;
            e_qj   = 32'(qj);
            e_qk   = 32'(qk);
        end
        e_sig = fire;
        if (bus.flush_in) begin
            for (int i = 0; i < 32; i++) m_status[i] = 0;
        end else begin
            crd = int'(bus.commit_rd_in);
            if (bus.commit_signal_in && m_status[crd] == int'(bus.commit_tag_in))
                m_status[crd] = 0;
            if (fire && bus.dec_rd_in != 0)
                m_status[int'(bus.dec_rd_in)] = int'(bus.rob_tail_tag_in);
        end
        m_run = !bus.flush_in;
        @(posedge clk);
        #1;
        chk("dis_signal", 32'(bus.dis_new_inst_signal_out), 32'(e_sig));
        chk("dis_inst", 32'(bus.dis_inst_out), e_inst);
        chk("dis_imm", bus.dis_imm_out, e_imm);
        chk("dis_pc", bus.dis_pc_out, e_pc);
        chk("dis_dest", 32'(bus.dis_dest_out), e_dest);
        chk("dis_Vj", bus.dis_Vj_out, e_vj);
        chk("dis_Vk", bus.dis_Vk_out, e_vk);
        chk("dis_Qj", 32'(bus.dis_Qj_out), e_qj);
        chk("dis_Qk", 32'(bus.dis_Qk_out), e_qk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_signal", 32'(bus.dis_new_inst_signal_out), 32'd0);
        chk("rst_dest", 32'(bus.dis_dest_out), 32'd0);
        chk("rst_Vj", bus.dis_Vj_out, 32'd0);
        chk("rst_Qj", 32'(bus.dis_Qj_out), 32'd0);
        chk("rst_Qk", 32'(bus.dis_Qk_out), 32'd0);
        chk("rst_pc", bus.dis_pc_out, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // First cycle after reset is the FLUSH state: no acceptance.
        set_dec(1, 1, 2, 3, 1'b1, 32'h0, 32'h100, 32'd5, 32'd7, 1);
        cycle();
        chk("flush_after_reset", 32'(bus.dis_new_inst_signal_out), 32'd0);

        // add x3,x1,x2
        cycle();
        chk("add_sig", 32'(bus.dis_new_inst_signal_out), 32'd1);
        chk("add_Vj", bus.dis_Vj_out, 32'd5);
        chk("add_Vk", bus.dis_Vk_out, 32'd7);
        chk("add_Qj", 32'(bus.dis_Qj_out), 32'd0);
        chk("add_dest", 32'(bus.dis_dest_out), 32'd1);
        clear_inputs();
        cycle();
        chk("add_pulse_drop", 32'(bus.dis_new_inst_signal_out), 32'd0);
        chk("add_hold_Vj", bus.dis_Vj_out, 32'd5);

        // sub x4,x3,x1 sees x3 pending on tag 1
        set_dec(2, 3, 1, 4, 1'b1, 32'h0, 32'h104, 32'hdead, 32'd5, 2);
        cycle();
        chk("sub_Qj", 32'(bus.dis_Qj_out), 32'd1);
        chk("sub_Vj", bus.dis_Vj_out, 32'd0);
        chk("sub_dest", 32'(bus.dis_dest_out), 32'd2);

        // commit x3/tag1, then x3 reads the register file
        clear_inputs();
        bus.commit_signal_in = 1'b1;
        bus.commit_rd_in     = 5'd3;
        bus.commit_tag_in    = 4'd1;
        cycle();
        set_dec(1, 3, 0, 5, 1'b1, 32'h0, 32'h108, 32'h33, 32'h44, 3);
        cycle();
        chk("commit_Qj", 32'(bus.dis_Qj_out), 32'd0);
        chk("commit_Vj", bus.dis_Vj_out, 32'h33);
        chk("x0_Vk", bus.dis_Vk_out, 32'd0);

        // x3 pending on tag 2, consumer dispatched while ALU broadcasts tag 2
        set_dec(3, 0, 0, 3, 1'b0, 32'h10, 32'h10c, 32'h0, 32'h0, 2);
        cycle();
        set_dec(1, 3, 0, 7, 1'b0, 32'h20, 32'h110, 32'h1234, 32'h0, 4);
        bus.alu_broadcast_signal_in = 1'b1;
        bus.alu_dest_tag_in         = 4'd2;
        bus.alu_result_in           = 32'h99;
        cycle();
`ifdef DISPATCH_BYPASS_EN
        chk("bypass_sig", 32'(bus.dis_new_inst_signal_out), 32'd1);
        chk("bypass_Qj", 32'(bus.dis_Qj_out), 32'd0);
        chk("bypass_Vj", bus.dis_Vj_out, 32'h99);
`else
        chk("hazard_stall", 32'(bus.dis_new_inst_signal_out), 32'd0);
        bus.alu_broadcast_signal_in = 1'b0;
        cycle();
        chk("hazard_issue", 32'(bus.dis_new_inst_signal_out), 32'd1);
        chk("hazard_Qj", 32'(bus.dis_Qj_out), 32'd2);
`endif

        // back-pressure from RS and ROB
        set_dec(4, 1, 0, 8, 1'b0, 32'h30, 32'h114, 32'h11, 32'h0, 5);
        bus.rs_full_in = 1'b1;
        cycle();
        chk("rs_full_sig", 32'(bus.dis_new_inst_signal_out), 32'd0);
        bus.rs_full_in  = 1'b0;
        bus.rob_full_in = 1'b1;
        cycle();
        chk("rob_full_sig", 32'(bus.dis_new_inst_signal_out), 32'd0);
        bus.rob_full_in = 1'b0;
        cycle();
        chk("unstall_sig", 32'(bus.dis_new_inst_signal_out), 32'd1);
        chk("unstall_dest", 32'(bus.dis_dest_out), 32'd5);

        // flush wipes renames and blocks dispatch for two cycles
        set_dec(5, 0, 0, 5, 1'b0, 32'h0, 32'h118, 32'h0, 32'h0, 3);
        cycle();
        set_dec(6, 5, 0, 9, 1'b0, 32'h0, 32'h11c, 32'h55, 32'h0, 6);
        bus.flush_in = 1'b1;
        cycle();
        chk("flush_cyc1", 32'(bus.dis_new_inst_signal_out), 32'd0);
        bus.flush_in = 1'b0;
        cycle();
        chk("flush_cyc2", 32'(bus.dis_new_inst_signal_out), 32'd0);
        cycle();
        chk("post_flush_sig", 32'(bus.dis_new_inst_signal_out), 32'd1);
        chk("post_flush_Qj", 32'(bus.dis_Qj_out), 32'd0);
        chk("post_flush_Vj", bus.dis_Vj_out, 32'h55);

        // stale commit and same-cycle fire/commit on one register
        set_dec(7, 0, 0, 6, 1'b0, 32'h0, 32'h120, 32'h0, 32'h0, 4);
        cycle();
        set_dec(7, 0, 0, 6, 1'b0, 32'h0, 32'h124, 32'h0, 32'h0, 5);
        cycle();
        clear_inputs();
        bus.commit_signal_in = 1'b1;
        bus.commit_rd_in     = 5'd6;
        bus.commit_tag_in    = 4'd4;
        cycle();
        set_dec(8, 6, 0, 10, 1'b0, 32'h0, 32'h128, 32'h66, 32'h0, 7);
        cycle();
        chk("stale_commit_Qj", 32'(bus.dis_Qj_out), 32'd5);
        set_dec(7, 0, 0, 6, 1'b0, 32'h0, 32'h12c, 32'h0, 32'h0, 6);
        bus.commit_signal_in = 1'b1;
        bus.commit_rd_in     = 5'd6;
        bus.commit_tag_in    = 4'd5;
        cycle();
        set_dec(8, 6, 0, 0, 1'b0, 32'h0, 32'h130, 32'h66, 32'h0, 8);
        cycle();
        chk("fire_wins_Qj", 32'(bus.dis_Qj_out), 32'd6);

        // randomized traffic over a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            int r1, r2, crd;
            r1 = int'($urandom_range(7));
            r2 = int'($urandom_range(7));
            set_dec(int'($urandom_range(63)), r1, r2, int'($urandom_range(7)),
                    $urandom_range(1) == 1, $urandom(), $urandom(), $urandom(), $urandom(),
                    int'($urandom_range(15, 1)));
            bus.dec_valid_in     = $urandom_range(3) != 0;
            bus.rob_full_in      = $urandom_range(9) == 0;
            bus.rs_full_in       = $urandom_range(9) == 0;
            bus.flush_in         = $urandom_range(39) == 0;
            crd                  = int'($urandom_range(7));
            bus.commit_signal_in = $urandom_range(2) == 0;
            bus.commit_rd_in     = 5'(crd);
            if ($urandom_range(1) == 1) bus.commit_tag_in = 4'(m_status[crd]);
            else bus.commit_tag_in = 4'($urandom_range(15));
            bus.alu_broadcast_signal_in = $urandom_range(9) < 4;
            bus.alu_result_in           = $urandom();
            if ($urandom_range(1) == 1 && m_status[r1] != 0)
                bus.alu_dest_tag_in = 4'(m_status[r1]);
            else
                bus.alu_dest_tag_in = 4'($urandom_range(15, 1));
            bus.lsb_broadcast_signal_in = $urandom_range(9) < 4;
            bus.lsb_result_in           = $urandom();
            if ($urandom_range(1) == 1 && m_status[r2] != 0)
                bus.lsb_dest_tag_in = 4'(m_status[r2]);
            else
                bus.lsb_dest_tag_in = 4'($urandom_range(15, 1));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
